fpu_issue_ctrl: RTL
===================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32, giving the maximum WAIT-state cycles before forced completion (range 2..255).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports insn_valid (input, 1) and insn_ready (output, 1), the instruction handshake.
REQ-005 SHALL have port insn, input, 32, an rv32zhinx_insn_t instruction.
REQ-006 SHALL have ports rs1_data, rs2_data and rs3_data, input, 16 each, operand values sampled with insn.
REQ-007 SHALL have port frm, input, 3, the dynamic rounding mode.
REQ-008 SHALL have ports op_valid (output, 1), op (output, 4, fpu_operation_t ordinal), op_rm (output, 3), and op_a, op_b, op_c (output, 16 each), the datapath issue.
REQ-009 SHALL have ports op_done (input, 1), op_result (input, 16) and op_flags (input, 5, NV/DZ/OF/UF/NX), the datapath completion.
REQ-010 SHALL have ports wb_valid (output, 1), wb_ready (input, 1), wb_rd (output, 5), wb_data (output, 16) and wb_flags (output, 5), the writeback handshake.
REQ-011 SHALL have port illegal_insn, output, 1, a one-cycle pulse on rejecting an instruction.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT and WB.
REQ-013 SHALL assert insn_ready only in IDLE; an instruction is accepted when insn_valid and insn_ready are both high.
REQ-014 SHALL decode as legal only when:
- opcode is OPFP, FMADD, FMSUB, FNMADD or FNMSUB;
- fmt = 2'b10;
- for OPFP, funct5 is in fpu_funct_t.
REQ-015 SHALL apply these rm rules:
- arithmetic ops: rm 000-100 is used as-is; rm 111 takes frm; frm >= 101 is illegal.
- MINMAX accepts rm 000/001 only.
- FCOMP accepts rm 000/001/010 only.
- SGNJ accepts rm 000-010 only.
- FSQRT requires rs2 = 0.
REQ-016 SHALL, on accepting an illegal instruction, pulse illegal_insn the next cycle, stay in IDLE, and issue no op or writeback.
REQ-017 SHALL, on accepting a legal instruction, register op, op_rm, op_a/op_b/op_c (from rs1/rs2/rs3_data), and rd, then enter ISSUE.
REQ-018 SHALL map MINMAX rm 000/001 to FPU_HALF_MIN/FPU_HALF_MAX, and pass the FCOMP/SGNJ rm selector through on op_rm.
REQ-019 SHALL hold op_valid high for exactly the one ISSUE cycle, then enter WAIT; op_done SHALL be ignored outside WAIT.
REQ-020 SHALL, on op_done in WAIT, register op_result and op_flags into wb_data and wb_flags and enter WB; wb_valid SHALL rise the following cycle.
REQ-021 SHALL, in WB, hold wb_valid, wb_rd, wb_data and wb_flags stable until wb_ready, then return to IDLE; a new instruction can be accepted the cycle after.
REQ-022 SHALL give minimum accept-to-wb_valid latency of 3 cycles (op_done on the first WAIT cycle).
REQ-023 SHALL keep the operand and op registers stable from ISSUE until WB exit.

Reset
REQ-024 SHALL, while nRST is low, force IDLE, clear the timeout counter, and drive every output to 0.
REQ-025 SHALL, on reset assertion mid-operation, drop op_valid/wb_valid immediately and discard the operation; a late op_done after reset SHALL be ignored.

Configuration
REQ-026 SHALL, with FPU_ISSUE_TIMEOUT_EN defined, count WAIT cycles; at TIMEOUT cycles without op_done it SHALL enter WB with wb_data = 16'hFFFF (HALF_NAN) and wb_flags = 5'b10000.
REQ-027 SHALL, without FPU_ISSUE_TIMEOUT_EN, contain no counter and wait in WAIT indefinitely; parameter TIMEOUT SHALL then be unused.

Verification
REQ-028 SHALL cover: insn 0x0420F0D3 (FADD.H, rm=DYN, rd=1), frm=000, rs1=0x3C00, rs2=0x4000 -> op=0, op_rm=000, op_a=0x3C00, op_b=0x4000; op_done with 0x4200 -> wb_rd=1, wb_data=0x4200.
REQ-029 SHALL cover: insn 0x0020F0D3 (fmt=single) -> one-cycle illegal_insn, no op_valid, insn_ready remains 1.
REQ-030 SHALL cover: wb_ready held low 5 cycles -> wb_valid and data stable, insn_ready 0 throughout, return to IDLE on the cycle after wb_ready.
REQ-031 SHALL cover: with macro defined, TIMEOUT=8 and no op_done -> WB after 8 WAIT cycles, wb_data=0xFFFF, wb_flags=5'b10000.
REQ-032 SHALL cover: nRST low during WAIT, then op_done pulsed after release -> all outputs 0, state IDLE, no wb_valid.
REQ-033 SHALL cover: FMINMAX with rm=001 -> op=5 (FPU_HALF_MAX); FSQRT with rs2=3 -> illegal_insn pulse.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback sequencer for a half-precision (Zhinx) FPU: decodes, issues one op, awaits completion, hands result back.
// Optional WAIT watchdog enabled by defining FPU_ISSUE_TIMEOUT_EN (parameter TIMEOUT then sets its length).
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        insn_valid,
    output logic        insn_ready,
    input  logic [31:0] insn,
    input  logic [15:0] rs1_data,
    input  logic [15:0] rs2_data,
    input  logic [15:0] rs3_data,
    input  logic [2:0]  frm,
    output logic        op_valid,
    output logic [3:0]  op,
    output logic [2:0]  op_rm,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [15:0] op_c,
    input  logic        op_done,
    input  logic [15:0] op_result,
    input  logic [4:0]  op_flags,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic [4:0]  wb_flags,
    output logic        illegal_insn
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_WB = 2'd3} state_t;

    localparam logic [6:0] OPC_OPFP   = 7'h53;
    localparam logic [6:0] OPC_FMADD  = 7'h43;
    localparam logic [6:0] OPC_FMSUB  = 7'h47;
    localparam logic [6:0] OPC_FNMSUB = 7'h4B;
    localparam logic [6:0] OPC_FNMADD = 7'h4F;

    // fpu_operation_t ordinals
    localparam logic [3:0] FPU_FADD = 4'd0, FPU_FSUB = 4'd1, FPU_FMUL = 4'd2, FPU_FDIV = 4'd3;
    localparam logic [3:0] FPU_HALF_MIN = 4'd4, FPU_HALF_MAX = 4'd5, FPU_FSQRT = 4'd6, FPU_SGNJ = 4'd7;
    localparam logic [3:0] FPU_FCOMP = 4'd8, FPU_FMADD = 4'd9, FPU_FMSUB = 4'd10;
    localparam logic [3:0] FPU_FNMADD = 4'd11, FPU_FNMSUB = 4'd12;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("fpu_issue_ctrl: TIMEOUT must be within 2..255");
    end

    state_t      state_q, state_d;
    logic        insn_ready_q, insn_ready_d, illegal_q, illegal_d;
    logic        op_valid_q, op_valid_d, wb_valid_q, wb_valid_d;
    logic [3:0]  op_q, op_d;
    logic [2:0]  op_rm_q, op_rm_d;
    logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [4:0]  rd_q, rd_d, wb_flags_q, wb_flags_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        dec_legal_s, dec_arith_s, accept_s;
    logic [3:0]  dec_op_s;
    logic [2:0]  dec_rm_s, eff_rm_s;
    logic        unused_s;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  cnt_q, cnt_d;
`endif

    assign unused_s = ^insn[19:15];
    assign accept_s = insn_valid & insn_ready_q;
    assign eff_rm_s = (insn[14:12] == 3'b111) ? frm : insn[14:12];

    // Instruction decode: legality, operation ordinal and effective rounding/selector field.
    always_comb begin
        dec_legal_s = 1'b0;
        dec_arith_s = 1'b0;
        dec_op_s    = FPU_FADD;
        dec_rm_s    = insn[14:12];
        case (insn[6:0])
            OPC_OPFP: begin
                case (insn[31:27])
                    5'b00000: begin dec_op_s = FPU_FADD; dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
                    5'b00001: begin dec_op_s = FPU_FSUB; dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
                    5'b00010: begin dec_op_s = FPU_FMUL; dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
                    5'b00011: begin dec_op_s = FPU_FDIV; dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
                    5'b00100: begin dec_op_s = FPU_SGNJ; dec_legal_s = (insn[14:12] <= 3'b010); end
                    5'b00101: begin
                        dec_op_s    = insn[12] ? FPU_HALF_MAX : FPU_HALF_MIN;
                        dec_legal_s = (insn[14:13] == 2'b00);
                    end
                    5'b01011: begin
                        dec_op_s    = FPU_FSQRT;
                        dec_arith_s = 1'b1;
                        dec_legal_s = (insn[24:20] == 5'd0);
                    end
                    5'b10100: begin dec_op_s = FPU_FCOMP; dec_legal_s = (insn[14:12] <= 3'b010); end
                    default:  begin dec_legal_s = 1'b0; end
                endcase
            end
            OPC_FMADD:  begin dec_op_s = FPU_FMADD;  dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
            OPC_FMSUB:  begin dec_op_s = FPU_FMSUB;  dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
            OPC_FNMADD: begin dec_op_s = FPU_FNMADD; dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
            OPC_FNMSUB: begin dec_op_s = FPU_FNMSUB; dec_arith_s = 1'b1; dec_legal_s = 1'b1; end
            default:    begin dec_legal_s = 1'b0; end
        endcase
        // Arithmetic ops resolve DYN through frm; reserved modes (101/110) are rejected either way.
        if (dec_arith_s) begin
            dec_rm_s = eff_rm_s;
            if (eff_rm_s > 3'b100) begin
                dec_legal_s = 1'b0;
            end else begin
                dec_legal_s = dec_legal_s;
            end
        end else begin
            dec_rm_s = insn[14:12];
        end
        if (insn[26:25] != 2'b10) begin
            dec_legal_s = 1'b0;
        end else begin
            dec_legal_s = dec_legal_s;
        end
    end

    // Next-state and next-output logic of the issue FSM.
    always_comb begin
        state_d    = state_q;
        illegal_d  = 1'b0;
        op_d       = op_q;
        op_rm_d    = op_rm_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_c_d     = op_c_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        wb_flags_d = wb_flags_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
        cnt_d      = 8'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s && dec_legal_s) begin
                    state_d = S_ISSUE;
                    op_d    = dec_op_s;
                    op_rm_d = dec_rm_s;
                    op_a_d  = rs1_data;
                    op_b_d  = rs2_data;
                    op_c_d  = rs3_data;
                    rd_d    = insn[11:7];
                end else begin
                    illegal_d = accept_s;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (op_done) begin
                    state_d    = S_WB;
                    wb_data_d  = op_result;
                    wb_flags_d = op_flags;
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = S_WB;
                    wb_data_d  = 16'hFFFF;
                    wb_flags_d = 5'b10000;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_WB: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        insn_ready_d = (state_d == S_IDLE);
        op_valid_d   = (state_d == S_ISSUE);
        wb_valid_d   = (state_d == S_WB);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            insn_ready_q <= 1'b0;
            illegal_q    <= 1'b0;
            op_valid_q   <= 1'b0;
            wb_valid_q   <= 1'b0;
            op_q         <= 4'd0;
            op_rm_q      <= 3'd0;
            op_a_q       <= 16'd0;
            op_b_q       <= 16'd0;
            op_c_q       <= 16'd0;
            rd_q         <= 5'd0;
            wb_data_q    <= 16'd0;
            wb_flags_q   <= 5'd0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            insn_ready_q <= insn_ready_d;
            illegal_q    <= illegal_d;
            op_valid_q   <= op_valid_d;
            wb_valid_q   <= wb_valid_d;
            op_q         <= op_d;
            op_rm_q      <= op_rm_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_c_q       <= op_c_d;
            rd_q         <= rd_d;
            wb_data_q    <= wb_data_d;
            wb_flags_q   <= wb_flags_d;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign insn_ready   = insn_ready_q;
    assign illegal_insn = illegal_q;
    assign op_valid     = op_valid_q;
    assign op           = op_q;
    assign op_rm        = op_rm_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_c         = op_c_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = rd_q;
    assign wb_data      = wb_data_q;
    assign wb_flags     = wb_flags_q;
endmodule
